// File: rtl/spw_ctrl_pkg.sv
// Shared encodings for the SpaceWire link start-up controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spw_ctrl_pkg;

  // Link start-up FSM states; the encoding is visible in STAT[1:0]
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_RUN     = 2'd2,
    ST_BACKOFF = 2'd3
  } state_e;

  // Register map (word addresses)
  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_TOUT = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;
  localparam logic [1:0] ADDR_CMD  = 2'd3;

  // CTRL bit positions
  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_AUTO   = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;
  localparam int unsigned CTRL_W      = 3;

  // CMD bit positions (write-one actions)
  localparam int unsigned CMD_CLR_CNT = 0;
  localparam int unsigned CMD_CLR_IRQ = 1;

  // STAT field positions
  localparam int unsigned STAT_STATE_LSB = 0;
  localparam int unsigned STAT_LINK_RUN  = 3;
  localparam int unsigned STAT_RETRY_LSB = 8;
  localparam int unsigned STAT_ERR_LSB   = 16;
  localparam int unsigned STAT_IRQ_PEND  = 31;

  // Retry and error counters are 8-bit saturating
  localparam int unsigned SAT_CNT_W = 8;

  // CTRL register image; field order puts enable at bit 0
  typedef struct packed {
    logic irq_en;
    logic auto_mode;
    logic enable;
  } ctrl_t;

endpackage

// File: rtl/spw_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
// Latency: count visible one clk after the inc/clr cycle.
// Backpressure: none; holds at all-ones instead of wrapping.
module spw_sat_counter
  import spw_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [SAT_CNT_W-1:0] cnt_o
);

  logic [SAT_CNT_W-1:0] cnt_q;
  logic [SAT_CNT_W-1:0] cnt_d;

  // Next count: clear first, then increment unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/spw_link_start_ctrl.sv
// SpaceWire link start-up sequencer with Avalon-MM register block.
// Latency: zero-wait reads; writes and FSM moves take effect on the next clk.
// Backpressure: none; slave always accepts, link outputs are Moore-decoded.
module spw_link_start_ctrl
  import spw_ctrl_pkg::*;
#(
  parameter int unsigned       CNT_W       = 16,
  parameter logic [CNT_W-1:0]  DEF_TIMEOUT = 16'd1280,
  parameter int unsigned       BACKOFF_CYC = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        link_running,
  input  logic        link_error,
  output logic        auto_start,
  output logic        link_start,
  output logic        link_disable,
  output logic        irq
);

  localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);
  localparam logic [CNT_W-1:0] BACKOFF_LAST = CNT_W'(BACKOFF_CYC - 1);

  // Register state
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] tout_q, tout_d;
  logic             irq_pend_q, irq_pend_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;

  // Bus decode
  logic wr_en;
  logic wr_ctrl, wr_tout, wr_cmd;
  logic clr_cnt, clr_irq;

  // FSM event strobes
  logic retry_inc, err_inc, irq_set;
  logic tout_hit;

  logic [SAT_CNT_W-1:0] retry_cnt, err_cnt;
  logic                 unused_wdata;

  assign wr_en   = chipselect & ~write_n;
  assign wr_ctrl = wr_en && (address == ADDR_CTRL);
  assign wr_tout = wr_en && (address == ADDR_TOUT);
  assign wr_cmd  = wr_en && (address == ADDR_CMD);
  assign clr_cnt = wr_cmd & writedata[CMD_CLR_CNT];
  assign clr_irq = wr_cmd & writedata[CMD_CLR_IRQ];

  assign unused_wdata = ^writedata[31:CNT_W];

  // Next values of the software-writable registers
  always_comb begin
    ctrl_d = ctrl_q;
    tout_d = tout_q;
    if (wr_ctrl) begin
      ctrl_d = ctrl_t'(writedata[CTRL_W-1:0]);
    end
    if (wr_tout) begin
      tout_d = writedata[CNT_W-1:0];
    end
  end

  // A zero TOUT disables the start timeout entirely
  assign tout_hit = (tout_q != '0) && (timer_q == (tout_q - ONE));

  // FSM next state and event strobes; the enable bit being written this
  // cycle is used so a CTRL write moves the FSM on the same clk edge
  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    err_inc   = 1'b0;
    irq_set   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_START;
      end
      ST_START: begin
        // A link that comes up on the timeout cycle still counts as a success
        if (link_running) begin
          state_d = ST_RUN;
        end else if (tout_hit) begin
          state_d   = ST_BACKOFF;
          retry_inc = 1'b1;
        end
      end
      ST_RUN: begin
        if (link_error || !link_running) begin
          state_d = ST_BACKOFF;
          err_inc = 1'b1;
          irq_set = 1'b1;
        end
      end
      ST_BACKOFF: begin
        if (timer_q == BACKOFF_LAST) begin
          state_d = ST_START;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Disable overrides every other transition and suppresses its events
    if (!ctrl_d.enable) begin
      state_d   = ST_IDLE;
      retry_inc = 1'b0;
      err_inc   = 1'b0;
      irq_set   = 1'b0;
    end
  end

  // Timer restarts from 0 on every state entry; it only runs where it is used
  always_comb begin
    timer_d = '0;
    if ((state_d == state_q) &&
        ((state_q == ST_START) || (state_q == ST_BACKOFF))) begin
      timer_d = timer_q + ONE;
    end
  end

  // A new link error wins over a simultaneous software acknowledge
  always_comb begin
    irq_pend_d = irq_pend_q;
    if (irq_set) begin
      irq_pend_d = 1'b1;
    end else if (clr_irq) begin
      irq_pend_d = 1'b0;
    end
  end

  // Control, status and FSM registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q     <= '0;
      tout_q     <= DEF_TIMEOUT;
      irq_pend_q <= 1'b0;
      state_q    <= ST_IDLE;
      timer_q    <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      tout_q     <= tout_d;
      irq_pend_q <= irq_pend_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
    end
  end

  spw_sat_counter u_retry_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (clr_cnt),
    .inc_i   (retry_inc),
    .cnt_o   (retry_cnt)
  );

  spw_sat_counter u_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (clr_cnt),
    .inc_i   (err_inc),
    .cnt_o   (err_cnt)
  );

  // Codec controls decoded from registered state only
  always_comb begin
    auto_start   = 1'b0;
    link_start   = 1'b0;
    link_disable = 1'b0;
    unique case (state_q)
      ST_START, ST_RUN: begin
        if (ctrl_q.auto_mode) begin
          auto_start = 1'b1;
        end else begin
          link_start = 1'b1;
        end
      end
      default: link_disable = 1'b1;
    endcase
  end

  assign irq = irq_pend_q & ctrl_q.irq_en;

  // Zero-wait read mux
  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_CTRL: readdata[CTRL_W-1:0] = ctrl_q;
      ADDR_TOUT: readdata = 32'(tout_q);
      ADDR_STAT: begin
        readdata[STAT_STATE_LSB +: 2]         = state_q;
        readdata[STAT_LINK_RUN]               = link_running;
        readdata[STAT_RETRY_LSB +: SAT_CNT_W] = retry_cnt;
        readdata[STAT_ERR_LSB +: SAT_CNT_W]   = err_cnt;
        readdata[STAT_IRQ_PEND]               = irq_pend_q;
      end
      default: readdata = '0;
    endcase
  end

endmodule
